branch_compare_unit: RTL and testbench

Branch-resolution stage of the integer pipeline. It accepts a decoded conditional branch (operands, funct3, PC, B-immediate) and time-multiplexes a single `comparatorX16` over the 32-bit operands: high half first (signed or unsigned), then low half (unsigned) only when the high halves are equal. It returns taken/not-taken and the next-PC target to fetch through a valid/ready handshake.

---
 rtl/branch_pkg.sv | 24 ++
 rtl/comparatorX16.sv | 18 +
 rtl/branch_compare_unit.sv | 127 ++++++++++++
 tb/tb_branch_compare_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch-resolution stage: funct3 codes, FSM states, word width.
package branch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

endpackage

// File: rtl/comparatorX16.sv
// 16-bit magnitude comparator; sign selects two's-complement or unsigned ordering.
module comparatorX16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        sign,
  output logic        greater,
  output logic        less,
  output logic        equal
);

  always_comb begin
    equal = (x == y);
    if (sign) less = ($signed(x) < $signed(y));
    else      less = (x < y);
    greater = !less && !equal;
  end

endmodule

// File: rtl/branch_compare_unit.sv
// Conditional-branch resolver: one shared 16-bit comparator walks the high half,
// then the low half only when the high halves match.
module branch_compare_unit #(
  parameter int unsigned XLEN = branch_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic            misaligned,
  output logic            illegal
);
  import branch_pkg::*;

  state_t          state;
  logic [XLEN-1:0] rs1_q, rs2_q, pc4_q, pct_q;
  logic [2:0]      f3_q;

  logic [15:0]     cmp_x, cmp_y;
  logic            cmp_sign, cmp_gt, cmp_lt, cmp_eq;
  logic            res_eq, res_taken;
  logic [XLEN-1:0] res_target;
  logic            res_mis;

  assign in_ready = !rst && (state == IDLE);

  always_comb begin
    cmp_x    = (state == LO) ? rs1_q[15:0] : rs1_q[31:16];
    cmp_y    = (state == LO) ? rs2_q[15:0] : rs2_q[31:16];
    cmp_sign = (state == HI) && ((f3_q == BLT) || (f3_q == BGE));
  end

  comparatorX16 u_cmp (
    .x       (cmp_x),
    .y       (cmp_y),
    .sign    (cmp_sign),
    .greater (cmp_gt),
    .less    (cmp_lt),
    .equal   (cmp_eq)
  );

  // Full-word equality is only possible once the low half has been compared;
  // in HI the resolve path is taken only when the high halves already differ.
  always_comb begin
    res_eq = (state == LO) && cmp_eq;
    unique case (f3_q)
      BEQ:        res_taken = res_eq;
      BNE:        res_taken = !res_eq;
      BLT, BLTU:  res_taken = cmp_lt;
      BGE, BGEU:  res_taken = cmp_gt || res_eq;
      default:    res_taken = 1'b0;
    endcase
    res_target = res_taken ? pct_q : pc4_q;
    res_mis    = res_taken && (pct_q[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      taken      <= 1'b0;
      target     <= '0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      pc4_q      <= '0;
      pct_q      <= '0;
      f3_q       <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            rs1_q <= rs1;
            rs2_q <= rs2;
            f3_q  <= funct3;
            pc4_q <= pc + 32'd4;
            pct_q <= pc + imm;
            if (is_illegal(funct3)) begin
              state      <= DONE;
              out_valid  <= 1'b1;
              illegal    <= 1'b1;
              taken      <= 1'b0;
              target     <= pc + 32'd4;
              misaligned <= 1'b0;
            end else begin
              state <= HI;
            end
          end
        end
        HI, LO: begin
          if (state == HI && cmp_eq) begin
            state <= LO;
          end else begin
            state      <= DONE;
            out_valid  <= 1'b1;
            illegal    <= 1'b0;
            taken      <= res_taken;
            target     <= res_target;
            misaligned <= res_mis;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_compare_unit.sv
// Self-checking bench for branch_compare_unit: directed table, random vectors, control corners.
module tb_branch_compare_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] rs1, rs2, pc, imm, target;
  logic [2:0]  funct3;
  logic        taken, misaligned, illegal;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  branch_compare_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .funct3(funct3), .pc(pc), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .taken(taken), .target(target), .misaligned(misaligned), .illegal(illegal)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, imm;
    logic        taken;
    logic [31:0] target;
    logic        mis, ill;
    int unsigned lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: full-word arithmetic compares; latency from whether the upper halves differ.
  function automatic vec_t model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] p, input logic [31:0] i);
    vec_t v;
    logic [31:0] t;
    v.f3 = f3; v.rs1 = a; v.rs2 = b; v.pc = p; v.imm = i;
    v.ill = 1'b0; v.taken = 1'b0;
    case (f3)
      3'd0: v.taken = (a == b);
      3'd1: v.taken = (a != b);
      3'd4: v.taken = ($signed(a) < $signed(b));
      3'd5: v.taken = ($signed(a) >= $signed(b));
      3'd6: v.taken = (a < b);
      3'd7: v.taken = (a >= b);
      default: v.ill = 1'b1;
    endcase
    t = p + i;
    v.target = v.taken ? t : p + 32'd4;
    v.mis = v.taken && (t % 4 != 0);
    v.lat = v.ill ? 1 : ((a >> 16) != (b >> 16)) ? 2 : 3;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    funct3 = v.f3; rs1 = v.rs1; rs2 = v.rs2; pc = v.pc; imm = v.imm;
  endtask

  // Issue at the next edge, then count edges (accept edge = 1) until out_valid.
  task automatic issue_and_wait(input vec_t v, input string tag, output int unsigned lat);
    drive(v);
    in_valid = 1'b1;
    chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input vec_t v, input string tag);
    chk({tag, " taken"},  {31'd0, taken},      {31'd0, v.taken});
    chk({tag, " target"}, target,              v.target);
    chk({tag, " mis"},    {31'd0, misaligned}, {31'd0, v.mis});
    chk({tag, " ill"},    {31'd0, illegal},    {31'd0, v.ill});
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int unsigned lat;
    issue_and_wait(v, tag, lat);
    chk({tag, " lat"}, lat, v.lat);
    check_result(v, tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " ovalid_clr"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " ready_back"}, {31'd0, in_ready},  32'd1);
  endtask

  vec_t tbl[10];

  initial begin
    int unsigned lat;
    vec_t v;
    tbl[0] = '{3'b100, 32'hFFFF0000, 32'h00000001, 32'h100, 32'h20, 1'b1, 32'h120, 1'b0, 1'b0, 2};
    tbl[1] = '{3'b110, 32'hFFFF0000, 32'h00000001, 32'h100, 32'h20, 1'b0, 32'h104, 1'b0, 1'b0, 2};
    tbl[2] = '{3'b000, 32'h12345678, 32'h12345678, 32'h200, 32'h40, 1'b1, 32'h240, 1'b0, 1'b0, 3};
    tbl[3] = '{3'b001, 32'h12345678, 32'h12345679, 32'h200, 32'h40, 1'b1, 32'h240, 1'b0, 1'b0, 3};
    tbl[4] = '{3'b101, 32'h80000000, 32'h7FFFFFFF, 32'h300, 32'h10, 1'b0, 32'h304, 1'b0, 1'b0, 2};
    tbl[5] = '{3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h300, 32'h10, 1'b1, 32'h310, 1'b0, 1'b0, 2};
    tbl[6] = '{3'b000, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h8, 1'b1, 32'h00000004, 1'b0, 1'b0, 3};
    tbl[7] = '{3'b000, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h2, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 3};
    tbl[8] = '{3'b010, 32'h5, 32'h5, 32'h400, 32'h80, 1'b0, 32'h404, 1'b0, 1'b1, 1};
    tbl[9] = '{3'b011, 32'h1, 32'h2, 32'h500, 32'h80, 1'b0, 32'h504, 1'b0, 1'b1, 1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rs1 = '0; rs2 = '0; pc = '0; imm = '0; funct3 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst taken",     {31'd0, taken},     32'd0);
    chk("rst target",    target,             32'd0);
    chk("rst in_ready",  {31'd0, in_ready},  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 2 == 0) ? {a[31:16], 16'($urandom)} : $urandom;
      if (i % 5 == 0) b = a;
      v = model(3'($urandom_range(0, 7)), a, b, $urandom, $urandom);
      run_vec(v, $sformatf("rnd%0d", i));
    end

    // out_ready withheld: result must stay put
    issue_and_wait(tbl[2], "hold", lat);
    chk("hold lat", lat, 3);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d valid", k), {31'd0, out_valid}, 32'd1);
      check_result(tbl[2], $sformatf("hold%0d", k));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // flush while in LO
    drive(tbl[2]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flushlo valid", {31'd0, out_valid}, 32'd0);
    chk("flushlo ready", {31'd0, in_ready},  32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("flushlo stays", {31'd0, out_valid}, 32'd0);

    // flush beats in_valid in IDLE
    drive(tbl[0]);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flushidle ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("flushidle valid", {31'd0, out_valid}, 32'd0);

    // flush together with out_ready in DONE
    issue_and_wait(tbl[0], "flushdone", lat);
    chk("flushdone lat", lat, 2);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    chk("flushdone valid", {31'd0, out_valid}, 32'd0);
    chk("flushdone ready", {31'd0, in_ready},  32'd1);

    // reset mid-HI after a taken result left nonzero outputs
    run_vec(tbl[7], "prerst");
    drive(tbl[0]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rsthi valid",  {31'd0, out_valid},  32'd0);
    chk("rsthi taken",  {31'd0, taken},      32'd0);
    chk("rsthi target", target,              32'd0);
    chk("rsthi mis",    {31'd0, misaligned}, 32'd0);
    chk("rsthi ill",    {31'd0, illegal},    32'd0);
    chk("rsthi ready",  {31'd0, in_ready},   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rsthi ready_after", {31'd0, in_ready},  32'd1);
    chk("rsthi valid_after", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
